kbd_strobe_fifo: RTL and testbench

- Sits between the PS/2-to-ASCII decoder and the Apple-1 PIA keyboard port (PA0-PA6, CA1).
- Buffers decoded keystrokes in a small FIFO and normalises them to Apple-1 conventions: upper case, rubout as '_'.
- Presents each character on a 7-bit bus with a timed strobe, then waits for a CPU read-acknowledge before releasing the next one.
- Prevents dropped keys when typing outruns the 6502 polling loop.

---
 rtl/kbd_strobe_fifo.sv | 181 ++++++++++++++++++
 tb/tb_kbd_strobe_fifo.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_strobe_fifo.sv
// rtl/kbd_strobe_fifo.sv - keystroke FIFO feeding the Apple-1 PIA keyboard port
//
// Buffers decoded ASCII keystrokes and hands them to the PIA one at a time.
// Each character is held on kbd_data with a timed strobe on CA1. The block
// then waits for the CPU read-acknowledge (or an optional timeout), and then
// holds a strobe-low gap before the next character.
//
// Ports:
//   clk         system clock (decoder domain)
//   rst_n       asynchronous active-low reset
//   clr         synchronous flush: empties FIFO, clears overflow, FSM to idle
//   ascii_new   decoder new-code flag; its rising edge is one push
//   ascii_code  decoder ASCII code, sampled on the push
//   kbd_ack     CPU read of the KBD register (level, already synchronised)
//   kbd_data    character presented to PA0-PA6; changes only on a pop
//   kbd_strobe  CA1 strobe, active high
//   fifo_count  current FIFO occupancy
//   overflow    sticky flag: a key was dropped because the FIFO was full
module kbd_strobe_fifo #(
  parameter int DEPTH         = 8,
  parameter int STROBE_CYCLES = 100,
  parameter int GAP_CYCLES    = 50,
  parameter int ACK_TIMEOUT   = 0,
  parameter bit UPCASE        = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       ascii_new,
  input  logic [6:0]                 ascii_code,
  input  logic                       kbd_ack,
  output logic [6:0]                 kbd_data,
  output logic                       kbd_strobe,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXA = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int MAXC = (MAXA > ACK_TIMEOUT) ? MAXA : ACK_TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);

  // One shared down-the-line counter; each state compares against its last value.
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT_ACK,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;
  logic [6:0]    data_q, data_d;
  logic          new_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic [6:0]    mem_q [DEPTH];

  logic          push, pop, full, wr_en;
  logic [6:0]    code_mapped;

  // Apple-1 conventions: backspace and DEL both become '_', optional upcase.
  always_comb begin
    code_mapped = ascii_code;
    if (ascii_code == 7'h08 || ascii_code == 7'h7F) begin
      code_mapped = 7'h5F;
    end else if (UPCASE && ascii_code >= 7'h61 && ascii_code <= 7'h7A) begin
      code_mapped = ascii_code - 7'h20;
    end
  end

  assign push  = ascii_new & ~new_q;
  assign pop   = (state_q == S_IDLE) && (count_q != '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  // A same-cycle pop frees the head slot, so a push into a full FIFO still fits.
  assign wr_en = push && (!full || pop);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          data_d   = mem_q[rd_ptr_q];
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_STROBE;
        end
      end
      S_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          strobe_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_ACK: begin
        if (kbd_ack) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (ACK_TIMEOUT > 0) begin
          if (cnt_q == TMO_LAST) begin
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        strobe_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
      data_q     <= 7'h00;
      new_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clr) begin
      // kbd_data deliberately survives a flush; the edge detector keeps
      // tracking so a level held across clr does not push afterwards.
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
      new_q      <= ascii_new;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      new_q    <= ascii_new;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!wr_en && pop) count_q <= count_q - (AW+1)'(1);
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem_q[wr_ptr_q] <= code_mapped;
  end

  assign kbd_data   = data_q;
  assign kbd_strobe = strobe_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_kbd_strobe_fifo.sv
// tb/tb_kbd_strobe_fifo.sv - randomized self-checking bench for kbd_strobe_fifo
module tb_kbd_strobe_fifo;

  logic       clk = 1'b0;
  logic       rst_n, clr, ascii_new, kbd_ack;
  logic [6:0] ascii_code;
  logic [6:0] kbd_data;
  logic       kbd_strobe, overflow;
  logic [3:0] fifo_count;

  logic       clr_b, ascii_new_b, ack_b;
  logic [6:0] ascii_code_b;
  logic [6:0] kbd_data_b;
  logic       kbd_strobe_b, overflow_b;
  logic [3:0] fifo_count_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fall_cyc;
  int min_gap;
  bit have_fall;
  logic [6:0] got_q[$];
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kbd_strobe_fifo #(.DEPTH(8), .STROBE_CYCLES(100), .GAP_CYCLES(50), .ACK_TIMEOUT(0), .UPCASE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ascii_new(ascii_new), .ascii_code(ascii_code),
    .kbd_ack(kbd_ack), .kbd_data(kbd_data), .kbd_strobe(kbd_strobe),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  kbd_strobe_fifo #(.DEPTH(8), .STROBE_CYCLES(100), .GAP_CYCLES(50), .ACK_TIMEOUT(200), .UPCASE(1'b1)) dut_tmo (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .ascii_new(ascii_new_b), .ascii_code(ascii_code_b),
    .kbd_ack(ack_b), .kbd_data(kbd_data_b), .kbd_strobe(kbd_strobe_b),
    .fifo_count(fifo_count_b), .overflow(overflow_b)
  );

  function automatic logic [6:0] model_map(input logic [6:0] c);
    if (c == 7'h08 || c == 7'h7F) return 7'h5F;
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
    return c;
  endfunction

  task automatic push_key(input logic [6:0] c);
    @(negedge clk);
    ascii_code = c;
    ascii_new  = 1'b1;
    @(negedge clk);
    ascii_new  = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Plays the CPU: collect each strobed character, then acknowledge it.
  task automatic serve(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (kbd_strobe !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
      total++;
      if (w >= 2000) begin bad++; $display("FAIL serve_rise: no strobe after %0d cycles, required one", w); end
      got_q.push_back(kbd_data);
      if (have_fall && (cyc - fall_cyc) < min_gap) min_gap = cyc - fall_cyc;
      w = 0;
      while (kbd_strobe !== 1'b0 && w < 500) begin @(negedge clk); w++; end
      total++;
      if (w >= 500) begin bad++; $display("FAIL serve_fall: strobe high %0d cycles, required it to fall", w); end
      fall_cyc  = cyc;
      have_fall = 1'b1;
      @(negedge clk); kbd_ack = 1'b1;
      @(negedge clk); kbd_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (kbd_data !== 7'h00) begin bad++; $display("FAIL reset_data: got %0h required 00", kbd_data); end
    total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %0b required 0", kbd_strobe); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b required 0", overflow); end
    total++; if (kbd_strobe_b !== 1'b0 || fifo_count_b !== 4'd0) begin
      bad++; $display("FAIL reset_tmo_inst: strobe %0b count %0d required 0 0", kbd_strobe_b, fifo_count_b);
    end
  endtask

  task automatic test_single(input logic [6:0] c);
    int n;
    bit seen;
    logic [6:0] e;
    e = model_map(c);
    @(negedge clk); ascii_code = c; ascii_new = 1'b1;
    @(negedge clk); ascii_new = 1'b0;
    total++; if (fifo_count !== 4'd1 || kbd_strobe !== 1'b0) begin
      bad++; $display("FAIL single_write: count %0d strobe %0b required 1 0", fifo_count, kbd_strobe);
    end
    @(negedge clk);
    total++; if (kbd_strobe !== 1'b1) begin bad++; $display("FAIL single_latency: strobe %0b two clocks after push, required 1", kbd_strobe); end
    total++; if (kbd_data !== e) begin bad++; $display("FAIL single_data: got %0h required %0h (code %0h)", kbd_data, e, c); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL single_pop_count: got %0d required 0", fifo_count); end
    n = 0;
    while (kbd_strobe === 1'b1 && n < 500) begin n++; @(negedge clk); end
    total++; if (n != 100) begin bad++; $display("FAIL single_strobe_len: got %0d required 100", n); end
    seen = 1'b0;
    repeat (300) begin @(negedge clk); if (kbd_strobe !== 1'b0) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL single_wait_ack: strobe rose without ack, required 0"); end
    @(negedge clk); kbd_ack = 1'b1;
    @(negedge clk); kbd_ack = 1'b0;
    repeat (80) begin @(negedge clk); if (kbd_strobe !== 1'b0) seen = 1'b1; end
    total++; if (seen || fifo_count !== 4'd0 || kbd_data !== e) begin
      bad++; $display("FAIL single_after_ack: extra strobe %0b count %0d data %0h required 0 0 %0h", seen, fifo_count, kbd_data, e);
    end
  endtask

  task automatic test_hold();
    bit seen;
    got_q.delete();
    @(negedge clk); ascii_code = 7'h0D; ascii_new = 1'b1;
    repeat (20) @(negedge clk);
    ascii_new = 1'b0;
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL hold_count: got %0d required 0", fifo_count); end
    serve(1);
    seen = 1'b0;
    repeat (200) begin @(negedge clk); if (kbd_strobe !== 1'b0) seen = 1'b1; end
    total++; if (seen || got_q.size() != 1) begin
      bad++; $display("FAIL hold_once: strobes %0d extra %0b required 1 0", got_q.size(), seen);
    end
    total++; if (got_q.size() > 0 && got_q[0] !== 7'h0D) begin bad++; $display("FAIL hold_data: got %0h required 0d", got_q[0]); end
  endtask

  task automatic test_rubout();
    got_q.delete();
    have_fall = 1'b0;
    min_gap   = 1000000;
    push_key(7'h7F);
    push_key(7'h08);
    serve(2);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL rubout_count: got %0d required 2", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== 7'h5F) begin bad++; $display("FAIL rubout_data%0d: got %0h required 5f", i, got_q[i]); end
    end
    total++; if (min_gap < 50) begin bad++; $display("FAIL rubout_gap: got %0d required >= 50", min_gap); end
  endtask

  task automatic test_overflow();
    logic [6:0] c;
    do_clr();
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      c = 7'($urandom_range(0, 127));
      if (i < 9) exp_q.push_back(model_map(c));
      push_key(c);
      if (i == 8) begin
        total++; if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
          bad++; $display("FAIL ovf_full: count %0d overflow %0b required 8 0", fifo_count, overflow);
        end
      end
    end
    total++; if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_drop: count %0d overflow %0b required 8 1", fifo_count, overflow);
    end
    serve(9);
    for (int i = 0; i < 9; i++) begin
      total++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL ovf_order%0d: got %0h required %0h", i, (i < got_q.size()) ? got_q[i] : 7'h00, exp_q[i]);
      end
    end
    total++; if (overflow !== 1'b1 || fifo_count !== 4'd0) begin
      bad++; $display("FAIL ovf_sticky: overflow %0b count %0d required 1 0", overflow, fifo_count);
    end
  endtask

  task automatic test_coincident();
    logic [6:0] c;
    int w;
    do_clr();
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      c = 7'($urandom_range(0, 127));
      exp_q.push_back(model_map(c));
      push_key(c);
    end
    got_q.push_back(kbd_data);
    w = 0;
    while (kbd_strobe !== 1'b0 && w < 500) begin @(negedge clk); w++; end
    @(negedge clk); kbd_ack = 1'b1;
    @(negedge clk); kbd_ack = 1'b0;
    repeat (50) @(negedge clk);
    total++; if (fifo_count !== 4'd8 || kbd_strobe !== 1'b0) begin
      bad++; $display("FAIL coin_pre: count %0d strobe %0b required 8 0", fifo_count, kbd_strobe);
    end
    c = 7'($urandom_range(0, 127));
    exp_q.push_back(model_map(c));
    ascii_code = c;
    ascii_new  = 1'b1;
    @(negedge clk);
    ascii_new  = 1'b0;
    total++; if (fifo_count !== 4'd8 || overflow !== 1'b0 || kbd_strobe !== 1'b1) begin
      bad++; $display("FAIL coin_accept: count %0d overflow %0b strobe %0b required 8 0 1", fifo_count, overflow, kbd_strobe);
    end
    serve(9);
    for (int i = 0; i < 10; i++) begin
      total++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL coin_order%0d: got %0h required %0h", i, (i < got_q.size()) ? got_q[i] : 7'h00, exp_q[i]);
      end
    end
  endtask

  task automatic test_clr();
    logic [6:0] c0;
    bit seen;
    do_clr();
    c0 = 7'($urandom_range(0, 127));
    push_key(c0);
    for (int i = 0; i < 3; i++) push_key(7'($urandom_range(0, 127)));
    repeat (10) @(negedge clk);
    total++; if (kbd_strobe !== 1'b1 || fifo_count !== 4'd3) begin
      bad++; $display("FAIL clr_pre: strobe %0b count %0d required 1 3", kbd_strobe, fifo_count);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++; if (kbd_strobe !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL clr_flush: strobe %0b count %0d overflow %0b required 0 0 0", kbd_strobe, fifo_count, overflow);
    end
    total++; if (kbd_data !== model_map(c0)) begin bad++; $display("FAIL clr_data_kept: got %0h required %0h", kbd_data, model_map(c0)); end
    seen = 1'b0;
    repeat (400) begin @(negedge clk); if (kbd_strobe !== 1'b0) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL clr_quiet: strobe rose after flush, required none"); end
    clr = 1'b1; ascii_code = 7'h41; ascii_new = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    ascii_new = 1'b0;
    @(negedge clk);
    total++; if (fifo_count !== 4'd0 || kbd_strobe !== 1'b0) begin
      bad++; $display("FAIL clr_push_drop: count %0d strobe %0b required 0 0", fifo_count, kbd_strobe);
    end
  endtask

  task automatic test_timeout();
    logic [6:0] c1, c2;
    int n;
    c1 = 7'($urandom_range(0, 127));
    c2 = 7'($urandom_range(0, 127));
    @(negedge clk); ascii_code_b = c1; ascii_new_b = 1'b1;
    @(negedge clk); ascii_new_b = 1'b0;
    @(negedge clk); ascii_code_b = c2; ascii_new_b = 1'b1;
    @(negedge clk); ascii_new_b = 1'b0;
    total++; if (kbd_strobe_b !== 1'b1 || kbd_data_b !== model_map(c1)) begin
      bad++; $display("FAIL tmo_first: strobe %0b data %0h required 1 %0h", kbd_strobe_b, kbd_data_b, model_map(c1));
    end
    n = 0;
    while (kbd_strobe_b !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    n = 0;
    while (kbd_strobe_b !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    total++; if (n != 251) begin bad++; $display("FAIL tmo_delay: got %0d required 251", n); end
    total++; if (kbd_data_b !== model_map(c2)) begin bad++; $display("FAIL tmo_second: got %0h required %0h", kbd_data_b, model_map(c2)); end
  endtask

  task automatic test_reset_mid();
    push_key(7'($urandom_range(7'h41, 7'h5A)));
    push_key(7'($urandom_range(7'h41, 7'h5A)));
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (kbd_strobe !== 1'b0 || kbd_strobe_b !== 1'b0) begin
      bad++; $display("FAIL rst_async_strobe: strobe %0b/%0b required 0/0", kbd_strobe, kbd_strobe_b);
    end
    total++; if (kbd_data !== 7'h00 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL rst_async_state: data %0h count %0d overflow %0b required 00 0 0", kbd_data, fifo_count, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; ascii_new = 1'b0; ascii_code = 7'h00; kbd_ack = 1'b0;
    clr_b = 1'b0; ascii_new_b = 1'b0; ascii_code_b = 7'h00; ack_b = 1'b0;
    fall_cyc = 0; min_gap = 1000000; have_fall = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_single(7'h61);
    test_single(7'($urandom_range(7'h61, 7'h7A)));
    test_single(7'($urandom_range(0, 127)));
    test_hold();
    test_rubout();
    test_overflow();
    test_coincident();
    test_clr();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
